sdr_read_serializer: RTL and testbench
======================================

Name: sdr_read_serializer

Overview:
- Target-side SDR private-read transmitter. Serializes each data byte MSB-first onto SDA, followed by the T-bit, and detects a controller abort after T=1.
- Feeds the push-pull SDA driver stage directly: its o_sda_push_pull/o_push_pull_en outputs connect to that stage's i_sda_push_pull/i_push_pull_en.
- Reads back SDA through that stage's o_sda_push_pull, which arrives here as i_sda.
- Consumes one-cycle SCL edge strobes from the target's SCL edge detector.

Parameters:
- DATA_W, 8, bits per data word before the T-bit.
- CNT_W, 3, bit-counter width; must equal clog2(DATA_W).

Ports:
- i_sys_clk  input  1  system clock.
- i_sys_rst  input  1  asynchronous, active-high reset.
- i_scl_neg_edge  input  1  one-cycle strobe, SCL falling edge (already synchronized).
- i_scl_pos_edge  input  1  one-cycle strobe, SCL rising edge.
- i_sda  input  1  sampled SDA line value.
- i_tx_en  input  1  level; transfer active while high; low forces idle.
- i_tx_valid  input  1  next byte available on i_tx_data.
- i_tx_data  input  DATA_W  byte to send.
- i_tx_last  input  1  this byte is the final one (its T-bit is 0).
- o_tx_ready  output  1  one-cycle pulse; byte captured from i_tx_data.
- o_sda_push_pull  output  1  1 = release high, 0 = drive low.
- o_push_pull_en  output  1  1 = drive SDA, 0 = high-Z.
- o_byte_done  output  1  one-cycle pulse after each T-bit completes.
- o_aborted  output  1  one-cycle pulse; controller aborted the read.
- o_busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0 except o_sda_push_pull = 1. Shift register and counter cleared.
- All outputs are registered. SDA changes exactly 1 cycle after the i_scl_neg_edge strobe.
- FSM states: IDLE, WAIT_FIRST, DATA, TBIT, TBIT_REL.
- IDLE:
  - On i_tx_en=1 and i_tx_valid=1: capture i_tx_data and i_tx_last, pulse o_tx_ready, go to WAIT_FIRST.
  - Outputs stay released.
- WAIT_FIRST:
  - On i_scl_neg_edge: drive MSB (o_push_pull_en=1, o_sda_push_pull=data[DATA_W-1]), counter=DATA_W-1, go to DATA.
- DATA:
  - Each i_scl_neg_edge: if counter>0, decrement and shift the next bit out.
  - When counter==0 on i_scl_neg_edge: drive T = ~last_q, go to TBIT.
- TBIT with T=0 (last byte):
  - On next i_scl_neg_edge: release (en=0, sda=1), pulse o_byte_done, go to IDLE.
- TBIT with T=1:
  - On i_scl_pos_edge: release SDA (en=0), go to TBIT_REL. The controller may pull SDA low to abort.
- TBIT_REL, on i_scl_neg_edge:
  - If i_sda==0: pulse o_aborted (no o_byte_done), go to IDLE.
  - Otherwise pulse o_byte_done.
    - If i_tx_valid: capture the next byte, pulse o_tx_ready, drive its MSB in the same cycle (no WAIT_FIRST), counter=DATA_W-1, go to DATA.
    - If not i_tx_valid (underflow): treat as abort-by-target: stay released, pulse o_aborted, go to IDLE.
- Simultaneous i_scl_pos_edge and i_scl_neg_edge in one cycle: illegal input; the neg edge takes priority.
- i_tx_en deasserted in any state: synchronous return to IDLE next cycle; SDA released; no done/abort pulse.
- Reset mid-byte: immediate release of SDA (o_push_pull_en=0).
- o_push_pull_en is never 1 in IDLE or TBIT_REL.

Decomposition:
- Shared package (i3c_target_pkg):
  - state encoding localparams for this FSM;
  - T_BIT_END=0 and T_BIT_MORE=1 constants;
  - SDA_RELEASE=1 and SDA_DRIVE_LOW=0.
- One natural sub-module: sdr_bit_shifter (DATA_W shift register plus down-counter with load/shift/zero flag). The FSM stays in the top module.

Test Plan:
- Single last byte 0xA5, i_tx_last=1, 10 SCL cycles:
  - SDA sequence 1,0,1,0,0,1,0,1 then T=0;
  - en=1 for 9 bit periods;
  - one o_byte_done; o_busy drops 1 cycle after the 10th neg edge.
- Two bytes 0x3C (last=0) then 0xFF (last=1), i_sda held high in TBIT_REL:
  - first T-bit driven 1, then released after the pos edge;
  - 0xFF MSB driven in the same cycle as the neg edge;
  - two o_byte_done pulses, two o_tx_ready pulses.
- Byte 0x81 with last=0, i_sda forced 0 during TBIT_REL:
  - o_aborted pulses once, no o_byte_done, en=0, state IDLE.
- Underflow: 0x55 with last=0, i_tx_valid=0 at the T-bit neg edge:
  - o_byte_done then o_aborted in the same cycle, SDA released.
- i_tx_en dropped after 3 bits of 0xC3:
  - next cycle en=0, sda=1, o_busy=0, no pulses.
- i_sys_rst asserted asynchronously mid-bit while driving 0:
  - o_push_pull_en=0 and o_sda_push_pull=1 without waiting for a clock edge;
  - transfer restarts cleanly after release.

Source files
------------

// File: rtl/i3c_target_pkg.sv
// Shared constants for the I3C target SDR read path.
// Holds the read-serializer state encoding, T-bit values and SDA drive levels.
package i3c_target_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_FIRST = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_TBIT       = 3'd3;
    localparam logic [2:0] ST_TBIT_REL   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_WAIT_FIRST = ST_WAIT_FIRST,
        S_DATA       = ST_DATA,
        S_TBIT       = ST_TBIT,
        S_TBIT_REL   = ST_TBIT_REL
    } sdr_state_e;

    // T-bit: 0 ends the read, 1 offers another byte.
    localparam logic T_BIT_END  = 1'b0;
    localparam logic T_BIT_MORE = 1'b1;

    localparam logic SDA_RELEASE   = 1'b1;
    localparam logic SDA_DRIVE_LOW = 1'b0;

endpackage

// File: rtl/sdr_read_serializer_if.sv
// Handshake / bus bundle for sdr_read_serializer.
//   slave  : the serializer side (SCL strobes, SDA readback and tx stream in;
//            SDA drive, handshake pulses and status out)
//   master : the surrounding target logic / bench side
interface sdr_read_serializer_if #(
    parameter int DATA_W = 8
);
    logic              i_scl_neg_edge;
    logic              i_scl_pos_edge;
    logic              i_sda;
    logic              i_tx_en;
    logic              i_tx_valid;
    logic [DATA_W-1:0] i_tx_data;
    logic              i_tx_last;
    logic              o_tx_ready;
    logic              o_sda_push_pull;
    logic              o_push_pull_en;
    logic              o_byte_done;
    logic              o_aborted;
    logic              o_busy;

    modport slave (
        input  i_scl_neg_edge, i_scl_pos_edge, i_sda,
        input  i_tx_en, i_tx_valid, i_tx_data, i_tx_last,
        output o_tx_ready, o_sda_push_pull, o_push_pull_en,
        output o_byte_done, o_aborted, o_busy
    );

    modport master (
        output i_scl_neg_edge, i_scl_pos_edge, i_sda,
        output i_tx_en, i_tx_valid, i_tx_data, i_tx_last,
        input  o_tx_ready, o_sda_push_pull, o_push_pull_en,
        input  o_byte_done, o_aborted, o_busy
    );
endinterface

// File: rtl/sdr_bit_shifter.sv
// MSB-first shift register with a bit down-counter.
//   load      : capture load_data, counter = DATA_W-1
//   shift     : shift left by one, counter - 1
//   next_bit  : the bit that becomes current after the next shift
//   msb       : the bit currently at the head of the register
//   cnt_zero  : counter has reached 0 (last data bit is on the wire)
module sdr_bit_shifter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic              msb,
    output logic              next_bit,
    output logic              cnt_zero
);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_data;
            cnt   <= CNT_W'(DATA_W - 1);
        end else if (shift) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
        end
    end

    assign msb      = shreg[DATA_W-1];
    assign next_bit = shreg[DATA_W-2];
    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/sdr_read_serializer.sv
// Target-side SDR private-read transmitter.
// Shifts each byte MSB-first onto SDA one cycle after each SCL falling-edge
// strobe, appends the T-bit, and after T=1 releases SDA on the rising edge so
// the controller can abort by holding SDA low.
//   i_sys_clk / i_sys_rst : clock, async active-high reset
//   bus (slave)           : SCL strobes, SDA readback, tx stream, SDA drive,
//                           tx_ready / byte_done / aborted pulses, busy
module sdr_read_serializer
    import i3c_target_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    sdr_read_serializer_if.slave  bus
);

    sdr_state_e state;
    logic       last_q;
    logic       sda_q;
    logic       en_q;
    logic       ready_q;
    logic       done_q;
    logic       aborted_q;
    logic       busy_q;

    logic       sh_load;
    logic       sh_shift;
    logic       sh_msb;
    logic       sh_next;
    logic       sh_zero;
    logic       cap_idle;
    logic       cap_chain;

    // Next byte may be taken either from IDLE or straight out of TBIT_REL
    // when the controller lets the read continue.
    assign cap_idle  = (state == S_IDLE) && bus.i_tx_en && bus.i_tx_valid;
    assign cap_chain = (state == S_TBIT_REL) && bus.i_tx_en && bus.i_scl_neg_edge
                       && bus.i_sda && bus.i_tx_valid;
    assign sh_load   = cap_idle || cap_chain;
    assign sh_shift  = (state == S_DATA) && bus.i_tx_en && bus.i_scl_neg_edge && !sh_zero;

    sdr_bit_shifter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .load      (sh_load),
        .load_data (bus.i_tx_data),
        .shift     (sh_shift),
        .msb       (sh_msb),
        .next_bit  (sh_next),
        .cnt_zero  (sh_zero)
    );

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state     <= S_IDLE;
            last_q    <= 1'b0;
            sda_q     <= SDA_RELEASE;
            en_q      <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (!bus.i_tx_en) begin
                state  <= S_IDLE;
                sda_q  <= SDA_RELEASE;
                en_q   <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        sda_q <= SDA_RELEASE;
                        en_q  <= 1'b0;
                        if (bus.i_tx_valid) begin
                            last_q  <= bus.i_tx_last;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state   <= S_WAIT_FIRST;
                        end
                    end
                    S_WAIT_FIRST: begin
                        if (bus.i_scl_neg_edge) begin
                            en_q  <= 1'b1;
                            sda_q <= sh_msb;
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (bus.i_scl_neg_edge) begin
                            if (!sh_zero) begin
                                sda_q <= sh_next;
                            end else begin
                                sda_q <= last_q ? T_BIT_END : T_BIT_MORE;
                                state <= S_TBIT;
                            end
                        end
                    end
                    S_TBIT: begin
                        // Neg edge wins over a simultaneous pos edge, so a T=1
                        // release only happens on a clean rising-edge strobe.
                        if (last_q) begin
                            if (bus.i_scl_neg_edge) begin
                                sda_q  <= SDA_RELEASE;
                                en_q   <= 1'b0;
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                                state  <= S_IDLE;
                            end
                        end else if (bus.i_scl_pos_edge && !bus.i_scl_neg_edge) begin
                            sda_q <= SDA_RELEASE;
                            en_q  <= 1'b0;
                            state <= S_TBIT_REL;
                        end
                    end
                    S_TBIT_REL: begin
                        if (bus.i_scl_neg_edge) begin
                            if (!bus.i_sda) begin
                                aborted_q <= 1'b1;
                                busy_q    <= 1'b0;
                                state     <= S_IDLE;
                            end else begin
                                done_q <= 1'b1;
                                if (bus.i_tx_valid) begin
                                    last_q  <= bus.i_tx_last;
                                    ready_q <= 1'b1;
                                    en_q    <= 1'b1;
                                    sda_q   <= bus.i_tx_data[DATA_W-1];
                                    state   <= S_DATA;
                                end else begin
                                    // Nothing queued: the target gives up the read.
                                    aborted_q <= 1'b1;
                                    busy_q    <= 1'b0;
                                    state     <= S_IDLE;
                                end
                            end
                        end
                    end
                    default: begin
                        sda_q  <= SDA_RELEASE;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_tx_ready      = ready_q;
    assign bus.o_sda_push_pull = sda_q;
    assign bus.o_push_pull_en  = en_q;
    assign bus.o_byte_done     = done_q;
    assign bus.o_aborted       = aborted_q;
    assign bus.o_busy          = busy_q;

endmodule

// File: tb/tb_sdr_read_serializer.sv
module tb_sdr_read_serializer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   done_cnt;
    int   abort_cnt;
    int   ready_cnt;

    sdr_read_serializer_if #(.DATA_W(8)) bus ();

    sdr_read_serializer #(.DATA_W(8), .CNT_W(3)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally, updated shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.o_byte_done === 1'b1) done_cnt++;
        if (bus.o_aborted === 1'b1) abort_cnt++;
        if (bus.o_tx_ready === 1'b1) ready_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wire bit k of a byte: 0..7 data MSB first, 8 is the T-bit.
    function automatic logic exp_bit(input logic [7:0] d, input bit last, input int k);
        if (k < 8) return d[7-k];
        return !last;
    endfunction

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic neg_strobe();
        @(negedge clk);
        bus.i_scl_neg_edge = 1'b1;
        @(negedge clk);
        bus.i_scl_neg_edge = 1'b0;
    endtask

    task automatic pos_strobe();
        @(negedge clk);
        bus.i_scl_pos_edge = 1'b1;
        @(negedge clk);
        bus.i_scl_pos_edge = 1'b0;
    endtask

    task automatic start_byte(input logic [7:0] d, input bit last);
        int r0;
        r0 = ready_cnt;
        @(negedge clk);
        bus.i_tx_valid = 1'b1;
        bus.i_tx_data  = d;
        bus.i_tx_last  = last;
        @(negedge clk);
        bus.i_tx_valid = 1'b0;
        chk("start_ready", ready_cnt - r0, 1);
        chk("start_busy", bus.o_busy, 1'b1);
        chk("start_en", bus.o_push_pull_en, 1'b0);
    endtask

    task automatic run_bits(input logic [7:0] d, input bit last, input int start_k);
        for (int k = start_k; k <= 8; k++) begin
            neg_strobe();
            chk("bit_sda", bus.o_sda_push_pull, exp_bit(d, last, k));
            chk("bit_en", bus.o_push_pull_en, 1'b1);
            gap();
            pos_strobe();
            if (k == 8 && !last) begin
                chk("trel_en", bus.o_push_pull_en, 1'b0);
                chk("trel_sda", bus.o_sda_push_pull, 1'b1);
            end else begin
                chk("hold_en", bus.o_push_pull_en, 1'b1);
            end
            gap();
        end
    endtask

    // Final falling edge of a T-bit period; the expected outcome follows the
    // read-termination rules: last byte ends, SDA low aborts, missing data
    // aborts after completing the byte, otherwise the next MSB goes out.
    task automatic tbit_end(input bit cur_last, input bit sda_in, input bit nv,
                            input logic [7:0] nd, input bit nl);
        int d0, a0, r0;
        int e_done, e_abort, e_ready;
        logic e_en, e_sda, e_busy;
        d0 = done_cnt; a0 = abort_cnt; r0 = ready_cnt;
        bus.i_sda      = sda_in;
        bus.i_tx_valid = nv;
        bus.i_tx_data  = nd;
        bus.i_tx_last  = nl;
        neg_strobe();
        bus.i_tx_valid = 1'b0;
        bus.i_sda      = 1'b1;
        if (cur_last) begin
            e_done = 1; e_abort = 0; e_ready = 0; e_en = 0; e_sda = 1; e_busy = 0;
        end else if (!sda_in) begin
            e_done = 0; e_abort = 1; e_ready = 0; e_en = 0; e_sda = 1; e_busy = 0;
        end else if (!nv) begin
            e_done = 1; e_abort = 1; e_ready = 0; e_en = 0; e_sda = 1; e_busy = 0;
        end else begin
            e_done = 1; e_abort = 0; e_ready = 1; e_en = 1; e_sda = nd[7]; e_busy = 1;
        end
        chk("end_done", done_cnt - d0, e_done);
        chk("end_abort", abort_cnt - a0, e_abort);
        chk("end_ready", ready_cnt - r0, e_ready);
        chk("end_en", bus.o_push_pull_en, e_en);
        chk("end_sda", bus.o_sda_push_pull, e_sda);
        chk("end_busy", bus.o_busy, e_busy);
        if (e_ready == 1) begin
            gap();
            pos_strobe();
            chk("chain_hold_en", bus.o_push_pull_en, 1'b1);
            gap();
        end
    endtask

    logic [7:0] rd;
    logic [7:0] rnd;
    int         nb;
    bit         ab;
    bit         nlast;
    int         d0, a0, r0;

    initial begin
        n_checks = 0; n_errors = 0;
        done_cnt = 0; abort_cnt = 0; ready_cnt = 0;
        rst = 1'b1;
        bus.i_scl_neg_edge = 1'b0;
        bus.i_scl_pos_edge = 1'b0;
        bus.i_sda          = 1'b1;
        bus.i_tx_en        = 1'b1;
        bus.i_tx_valid     = 1'b0;
        bus.i_tx_data      = '0;
        bus.i_tx_last      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sda", bus.o_sda_push_pull, 1'b1);
        chk("rst_en", bus.o_push_pull_en, 1'b0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_pulses", {bus.o_tx_ready, bus.o_byte_done, bus.o_aborted}, 3'b000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single last byte 0xA5.
        start_byte(8'hA5, 1'b1);
        run_bits(8'hA5, 1'b1, 0);
        tbit_end(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // 0x3C then 0xFF chained straight out of TBIT_REL.
        start_byte(8'h3C, 1'b0);
        run_bits(8'h3C, 1'b0, 0);
        tbit_end(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        run_bits(8'hFF, 1'b1, 1);
        tbit_end(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Controller abort on 0x81.
        start_byte(8'h81, 1'b0);
        run_bits(8'h81, 1'b0, 0);
        tbit_end(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);

        // Underflow after 0x55.
        start_byte(8'h55, 1'b0);
        run_bits(8'h55, 1'b0, 0);
        tbit_end(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // tx_en dropped after three bits of 0xC3.
        start_byte(8'hC3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            neg_strobe();
            chk("en_drop_bit", bus.o_sda_push_pull, exp_bit(8'hC3, 1'b1, k));
            pos_strobe();
        end
        d0 = done_cnt; a0 = abort_cnt; r0 = ready_cnt;
        @(negedge clk);
        bus.i_tx_en = 1'b0;
        @(negedge clk);
        chk("txen_en", bus.o_push_pull_en, 1'b0);
        chk("txen_sda", bus.o_sda_push_pull, 1'b1);
        chk("txen_busy", bus.o_busy, 1'b0);
        chk("txen_pulses", (done_cnt - d0) + (abort_cnt - a0) + (ready_cnt - r0), 0);
        bus.i_tx_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("txen_idle", bus.o_busy, 1'b0);

        // Async reset while driving a 0 bit.
        start_byte(8'h12, 1'b1);
        neg_strobe();
        chk("prerst_sda", bus.o_sda_push_pull, 1'b0);
        chk("prerst_en", bus.o_push_pull_en, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", bus.o_push_pull_en, 1'b0);
        chk("async_rst_sda", bus.o_sda_push_pull, 1'b1);
        chk("async_rst_busy", bus.o_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_byte(8'h6E, 1'b1);
        run_bits(8'h6E, 1'b1, 0);
        tbit_end(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Random multi-byte reads with occasional controller aborts.
        for (int s = 0; s < 6; s++) begin
            nb = $urandom_range(1, 3);
            rd = 8'($urandom);
            start_byte(rd, nb == 1);
            run_bits(rd, nb == 1, 0);
            for (int b = 0; b < nb; b++) begin
                if (b == nb - 1) begin
                    tbit_end(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
                    break;
                end
                ab    = ($urandom_range(0, 3) == 0);
                rnd   = 8'($urandom);
                nlast = (b + 1 == nb - 1);
                tbit_end(1'b0, !ab, 1'b1, rnd, nlast);
                if (ab) break;
                rd = rnd;
                run_bits(rd, nlast, 1);
            end
            repeat (2) @(negedge clk);
            chk("rand_idle", bus.o_busy, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
